// File: rtl/obc_dct_sequencer.sv
// Shared scheduler for the 16-point OBC distributed-arithmetic DCT: captures one
// frame, serialises it LSB-first as ROM addresses and drives the accumulator strobes.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds in_valid/in_data until it sees in_ready. The sequencer holds
// out_valid until it sees out_ready. Neither ready depends combinationally on its valid.
module obc_dct_sequencer #(
  parameter int N     = 32,
  parameter int P     = 16,
  parameter int CNT_W = 5,
  parameter int FC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P*N-1:0]   in_data,
  output logic [P-1:0]     bit_vec,
  output logic [CNT_W-1:0] bit_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [FC_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     sr [P];
  logic [CNT_W-1:0] idx_r;
  logic [FC_W-1:0]  fc_r;
  logic             accept;
  logic             last_bit;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (idx_r == CNT_W'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_r <= '0;
      fc_r  <= '0;
      for (int k = 0; k < P; k++) sr[k] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_r <= '0;
            for (int k = 0; k < P; k++) sr[k] <= in_data[k*N +: N];
          end
        end
        RUN: begin
          // Shift right so bit 0 of each register is always the current bit.
          for (int k = 0; k < P; k++) sr[k] <= sr[k] >> 1;
          idx_r <= last_bit ? '0 : idx_r + 1'b1;
        end
        DONE: if (out_ready) fc_r <= fc_r + 1'b1;
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_sub   = 1'b0;
    out_valid = 1'b0;
    bit_vec   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOAD: begin
        acc_clr = 1'b1;
        for (int k = 0; k < P; k++) bit_vec[k] = sr[k][0];
      end
      RUN: begin
        acc_en  = 1'b1;
        acc_sub = last_bit;
        for (int k = 0; k < P; k++) bit_vec[k] = sr[k][0];
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bit_idx   = idx_r;
  assign frame_cnt = fc_r;

endmodule

// File: tb/tb_obc_dct_sequencer.sv
// Bench for obc_dct_sequencer: directed frames, a scoreboard of expected strobe /
// ROM-address beats, and a monitor that checks every beat the sequencer presents.
module tb_obc_dct_sequencer;

  localparam int N     = 32;
  localparam int P     = 16;
  localparam int CNT_W = 5;
  localparam int FC_W  = 8;
  localparam int W     = 2 + CNT_W + P;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [P*N-1:0]   in_data;
  logic [P-1:0]     bit_vec;
  logic [CNT_W-1:0] bit_idx;
  logic             acc_clr;
  logic             acc_en;
  logic             acc_sub;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [FC_W-1:0]  frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0]    exp_q[$];
  logic [FC_W-1:0] model_fc = '0;

  obc_dct_sequencer #(.N(N), .P(P), .CNT_W(CNT_W), .FC_W(FC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bit_vec(bit_vec), .bit_idx(bit_idx), .acc_clr(acc_clr),
    .acc_en(acc_en), .acc_sub(acc_sub), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P-1:0] bits_of(input logic [P*N-1:0] d, input int b);
    logic [P-1:0] v;
    for (int k = 0; k < P; k++) v[k] = d[k*N + b];
    return v;
  endfunction

  task automatic wait_flag(input string name, input int which, input int limit);
    int n = 0;
    logic hit;
    do begin
      tick();
      n++;
      hit = (which == 0) ? acc_clr : (which == 1) ? out_valid : in_ready;
    end while (!hit && n < limit);
    if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (acc_clr || acc_en) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {acc_clr, acc_sub, bit_idx, bit_vec}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("beat", 32'({acc_clr, acc_sub, bit_idx, bit_vec}), 32'(e));
      end
    end
    if (out_valid) begin
      chk("frame_cnt_out", 32'(frame_cnt), 32'(model_fc));
      if (out_ready && !rst) model_fc = model_fc + 1'b1;
    end
    if (in_valid && in_ready && !rst) begin
      exp_q.push_back({1'b1, 1'b0, CNT_W'(0), bits_of(in_data, 0)});
      for (int b = 0; b < N; b++)
        exp_q.push_back({1'b0, (b == N - 1), CNT_W'(b), bits_of(in_data, b)});
    end
    if (rst) begin
      exp_q.delete();
      model_fc = '0;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [P*N-1:0] orig;
    int t0, en_cnt, last_clr, n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_bit_vec", 32'(bit_vec), 32'h0000);

    // Alternating frame, timing and backpressure.
    for (int k = 0; k < P; k++) in_data[k*N +: N] = (k % 2 == 0) ? 32'h0051EB85 : 32'h00624DD2;
    in_valid = 1'b1;
    tick();
    t0 = cyc - 1;
    in_valid = 1'b0;
    in_data = '1;
    chk("load_acc_clr", 32'(acc_clr), 32'd1);
    chk("load_acc_en", 32'(acc_en), 32'd0);
    chk("load_bit_vec", 32'(bit_vec), 32'h5555);
    en_cnt = 0;
    for (int i = 0; i < N; i++) begin
      tick();
      if (acc_en) en_cnt++;
      if (acc_clr) chk("acc_clr_in_run", 32'(acc_clr), 32'd0);
      if (i == 0) chk("bv_idx0", 32'(bit_vec), 32'h5555);
      if (i == 1) chk("bv_idx1", 32'(bit_vec), 32'hAAAA);
      if (i == 31) begin
        chk("bv_idx31", 32'(bit_vec), 32'h0000);
        chk("sub_idx31", 32'(acc_sub), 32'd1);
      end
    end
    chk("acc_en_cycles", 32'(en_cnt), 32'd32);
    tick();
    chk("done_latency", 32'(cyc - t0), 32'd34);
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_acc_en", 32'(acc_en), 32'd0);
    chk("done_bit_vec", 32'(bit_vec), 32'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!out_valid || in_ready || frame_cnt != 0)
        chk("backpressure_hold", {out_valid, in_ready, frame_cnt}, {1'b1, 1'b0, 8'd0});
    end
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Busy-period input is ignored; out_ready held high outside DONE is harmless.
    for (int k = 0; k < P; k++) in_data[k*N +: N] = 32'h1234_5678 ^ (32'(k) * 32'h0101_0101);
    orig = in_data;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_data = ~orig;
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    n = 0;
    while (bit_idx != 8 && n < 40) begin tick(); n++; end
    chk("busy_bv_idx8", 32'(bit_vec), 32'(bits_of(orig, 8)));
    wait_flag("busy_in_ready", 2, 60);
    out_ready = 1'b0;
    chk("busy_frame_cnt", 32'(frame_cnt), 32'd2);
    tick();
    chk("busy_no_capture", 32'(busy), 32'd0);

    // Reset in the middle of RUN.
    in_data = orig;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (bit_idx != 10 && n < 40) begin tick(); n++; end
    chk("mid_run_idx", 32'(bit_idx), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_acc_en", 32'(acc_en), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (out_valid) n++; end
    chk("mid_rst_no_out_valid", 32'(n), 32'd0);

    // Back-to-back frames with frame counter wrap.
    out_ready = 1'b1;
    in_valid = 1'b1;
    last_clr = 0;
    for (int f = 0; f < 257; f++) begin
      wait_flag("frame_start", 0, 100);
      if (f > 0) chk("frame_period", 32'(cyc - last_clr), 32'd35);
      last_clr = cyc;
      if (f == 256) in_valid = 1'b0;
      for (int k = 0; k < P; k++) in_data[k*N +: N] = 32'(f) * 32'h9E37_79B9 + 32'(k);
    end
    wait_flag("final_idle", 2, 60);
    out_ready = 1'b0;
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd1);
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
